label_rev_lut: RTL and testbench

//  Writable reverse branch-target table: maps a 12-bit PC back to its 8-bit label.

---
 rtl/label_rev_lut.sv | 123 ++++++++++++
 tb/tb_label_rev_lut.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/label_rev_lut.sv
// Reverse branch-target table: maps a stored PC back to the lowest label holding it.
// Loaded one (label, pc) pair per cycle; searched one entry per cycle behind a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_SCAN | comparing entry r_idx against the latched PC
// S_DONE | response held on rsp_* until rsp_ready
module label_rev_lut #(
    parameter int LABEL_W = 8,
    parameter int PC_W    = 12,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [LABEL_W-1:0] wr_label,
    input  logic [PC_W-1:0]    wr_pc,
    output logic               wr_err,
    input  logic               req_valid,
    input  logic [PC_W-1:0]    req_pc,
    output logic               req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [LABEL_W-1:0] rsp_label,
    output logic               busy
);

    localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LABEL_W:0]   DEPTH_L  = (LABEL_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t               r_state;
    logic [PC_W-1:0]      r_pc [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [PC_W-1:0]      r_req_pc;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_rsp_valid;
    logic                 r_rsp_hit;
    logic [LABEL_W-1:0]   r_rsp_label;
    logic                 r_wr_err;

    logic                 w_wr_ok;
    logic [IDX_W-1:0]     w_wr_idx;
    logic                 w_match;

    assign w_wr_ok  = wr_en && ({1'b0, wr_label} < DEPTH_L);
    assign w_wr_idx = wr_label[IDX_W-1:0];
    assign w_match  = r_valid[r_idx] && (r_pc[r_idx] == r_req_pc);

    // PC storage carries no reset; an entry is only meaningful once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_pc[w_wr_idx] <= wr_pc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            if (clear)
                r_valid <= '0;
            else if (w_wr_ok)
                r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_req_pc    <= '0;
            r_idx       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_label <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_pc <= req_pc;
                        r_idx    <= '0;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_rsp_hit   <= 1'b1;
                        r_rsp_label <= LABEL_W'(r_idx);
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_rsp_hit   <= 1'b0;
                        r_rsp_label <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_label = r_rsp_label;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_label_rev_lut.sv
// Bench for label_rev_lut: directed scenarios plus randomized loads/searches against
// an array model that resolves each search as "lowest label whose entry matched when the scan reached it".
module tb_label_rev_lut;

    localparam int LABEL_W = 8;
    localparam int PC_W    = 12;
    localparam int DEPTH   = 64;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               clear = 1'b0;
    logic               wr_en = 1'b0;
    logic [LABEL_W-1:0] wr_label = '0;
    logic [PC_W-1:0]    wr_pc = '0;
    logic               wr_err;
    logic               req_valid = 1'b0;
    logic [PC_W-1:0]    req_pc = '0;
    logic               req_ready;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_hit;
    logic [LABEL_W-1:0] rsp_label;
    logic               busy;

    label_rev_lut #(.LABEL_W(LABEL_W), .PC_W(PC_W), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_label  (wr_label),
        .wr_pc     (wr_pc),
        .wr_err    (wr_err),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_label (rsp_label),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] m_pc    [DEPTH];
    bit          m_valid [DEPTH];
    bit          m_err = 1'b0;

    // writes/clear to inject during a scan, keyed by cycle offset from the accept edge
    int s_cyc [4];
    int s_lbl [4];
    int s_pcv [4];
    int s_n   = 0;
    int s_clr = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_err = 1'b0;
    endtask

    // one clock; inputs are stable across the edge, so the model updates from them afterwards
    task automatic tick();
        @(posedge clk);
        #1;
        m_err = wr_en && (int'(wr_label) >= DEPTH);
        if (clear) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (wr_en && int'(wr_label) < DEPTH) begin
            m_pc[int'(wr_label)]    = wr_pc;
            m_valid[int'(wr_label)] = 1'b1;
        end
        check_val("wr_err", {31'b0, wr_err}, {31'b0, m_err});
    endtask

    task automatic wr(input int lbl, input int pc);
        wr_en    = 1'b1;
        wr_label = lbl[7:0];
        wr_pc    = pc[11:0];
        tick();
        wr_en = 1'b0;
    endtask

    task automatic search(input logic [11:0] pc, input int hold, input string tag);
        int         found_k;
        int         lat;
        int         exp_lat;
        logic       exp_hit;
        logic [7:0] exp_lbl;
        check_val({tag, "/req_ready"}, {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
        req_pc    = 12'($urandom);
        check_val({tag, "/busy"}, {31'b0, busy}, 1);
        found_k = -1;
        lat     = 0;
        for (int c = 0; c < 100; c++) begin
            for (int j = 0; j < s_n; j++) begin
                if (s_cyc[j] == c) begin
                    wr_en    = 1'b1;
                    wr_label = s_lbl[j][7:0];
                    wr_pc    = s_pcv[j][11:0];
                end
            end
            if (s_clr == c) clear = 1'b1;
            if (found_k < 0 && c < DEPTH && m_valid[c] && m_pc[c] == pc) found_k = c;
            tick();
            wr_en = 1'b0;
            clear = 1'b0;
            if (rsp_valid) begin
                lat = c + 1;
                break;
            end
        end
        exp_hit = (found_k >= 0);
        exp_lat = exp_hit ? found_k + 1 : DEPTH;
        exp_lbl = exp_hit ? 8'(found_k) : 8'd0;
        check_val({tag, "/latency"}, lat, exp_lat);
        check_val({tag, "/hit"}, {31'b0, rsp_hit}, {31'b0, exp_hit});
        check_val({tag, "/label"}, {24'b0, rsp_label}, {24'b0, exp_lbl});
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_pc    = 12'($urandom);
            tick();
            check_val({tag, "/hold_valid"}, {31'b0, rsp_valid}, 1);
            check_val({tag, "/hold_hit"}, {31'b0, rsp_hit}, {31'b0, exp_hit});
            check_val({tag, "/hold_label"}, {24'b0, rsp_label}, {24'b0, exp_lbl});
            check_val({tag, "/hold_ready"}, {31'b0, req_ready}, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val({tag, "/done_valid"}, {31'b0, rsp_valid}, 0);
        check_val({tag, "/done_ready"}, {31'b0, req_ready}, 1);
        check_val({tag, "/done_busy"}, {31'b0, busy}, 0);
        s_n   = 0;
        s_clr = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #10;
        check_val("rst/rsp_valid", {31'b0, rsp_valid}, 0);
        check_val("rst/rsp_hit", {31'b0, rsp_hit}, 0);
        check_val("rst/rsp_label", {24'b0, rsp_label}, 0);
        check_val("rst/wr_err", {31'b0, wr_err}, 0);
        check_val("rst/req_ready", {31'b0, req_ready}, 1);
        check_val("rst/busy", {31'b0, busy}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // T2: labels 0..43, duplicate PC 2 at 0 and 1
        for (int i = 0; i < 44; i++)
            wr(i, (i < 2) ? 2 : (i == 2) ? 352 : 402 + i);
        search(12'd352, 0, "t2");

        // T3
        search(12'd2, 0, "t3_dup");
        search(12'd999, 0, "t3_miss");

        // T4: out-of-range write, then clear racing a write
        wr(70, 123);
        check_val("t4/wr_err_pulse", {31'b0, wr_err}, 1);
        tick();
        search(12'd123, 0, "t4_oor");
        search(12'd352, 0, "t4_keep");
        clear    = 1'b1;
        wr_en    = 1'b1;
        wr_label = 8'd3;
        wr_pc    = 12'd777;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        search(12'd777, 0, "t4_clrwr");
        search(12'd2, 0, "t4_empty");

        // T5: writes during the scan of 625 (label 30 written on its own compare edge)
        s_cyc[0] = 7;  s_lbl[0] = 5;  s_pcv[0] = 625;
        s_cyc[1] = 20; s_lbl[1] = 60; s_pcv[1] = 625;
        s_cyc[2] = 30; s_lbl[2] = 30; s_pcv[2] = 625;
        s_n = 3;
        search(12'd625, 0, "t5_scan");
        search(12'd625, 0, "t5_after");

        // T6
        search(12'd625, 10, "t6_hold");

        // T1: reset in the middle of a scan
        req_valid = 1'b1;
        req_pc    = 12'd999;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_val("t1/rsp_valid", {31'b0, rsp_valid}, 0);
        check_val("t1/req_ready", {31'b0, req_ready}, 1);
        check_val("t1/busy", {31'b0, busy}, 0);
        #3 reset_n = 1'b1;
        tick();
        check_val("t1/no_rsp", {31'b0, rsp_valid}, 0);
        search(12'd625, 0, "t1_after");

        // randomized loads, clears, in-scan writes and response stalls
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = int'($urandom_range(0, 6));
            for (int k = 0; k < nw; k++)
                wr(int'($urandom_range(0, 69)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            s_n = int'($urandom_range(0, 2));
            for (int j = 0; j < s_n; j++) begin
                s_cyc[j] = j * 20 + int'($urandom_range(0, 19));
                s_lbl[j] = int'($urandom_range(0, 69));
                s_pcv[j] = int'($urandom_range(0, 15));
            end
            s_clr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : -1;
            search(12'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
